vote_sequencer: RTL and testbench
=================================

# vote_sequencer

Session controller for the electronic ballot box. It takes one-cycle key events from the debounced keypad and sequences each vote through digit entry, confirmation, tally update and acknowledge display. It owns the per-candidate, null and blank vote counters and exposes them through a registered read port for the count-out phase. It sits between the keypad debouncer and the HEX display / tally readout logic.

## Interface
- NUM_CAND, 4: number of candidates; valid codes are 10 .. 9+NUM_CAND (range 1..90)
- CNT_W, 8: width of every vote counter
- SHOW_CYC, 50000000: cycles the acknowledge pattern is held after a vote
- TIMEOUT, 500000000: idle-key cycles allowed during an unfinished vote before it is discarded
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- key_valid  in  1  one-cycle strobe: key_code is valid
- key_code  in  4  0-9 = digit, 10 = CONFIRMA, 11 = CORRIGE, 12 = BRANCO, 13-15 ignored
- close_poll  in  1  level; ends the election
- rd_idx  in  7  tally index: 0..NUM_CAND-1 = candidate, NUM_CAND = null, NUM_CAND+1 = blank
- rd_data  out  CNT_W  registered counter value for rd_idx
- disp_d1, disp_d0  out  4 each  tens/units display nibble; 4'hF = blank digit, 4'hA = acknowledge
- state_o  out  3  current state encoding (below)
- vote_done  out  1  one-cycle pulse per committed vote
- closed  out  1  high in CLOSED

## Operation
- States (state_o): IDLE=0, DIGIT2=1, CONFIRM=2, COMMIT=3, SHOW=4, CLOSED=5.
- IDLE: digit -> latch d1, DIGIT2. BRANCO -> set blank flag, CONFIRM. close_poll=1 (no key this cycle) -> CLOSED. Other keys ignored. Display F,F.
- DIGIT2: digit -> latch d0, CONFIRM. CORRIGE -> clear d1/d0/blank, IDLE. Other keys ignored. Display d1,F.
- CONFIRM: CONFIRMA -> COMMIT. CORRIGE -> clear, IDLE. Other keys ignored. Display d1,d0 (F,F if blank flag).
- COMMIT (exactly 1 cycle): blank flag -> blank counter +1; else code = 10*d1+d0; 10 <= code <= 9+NUM_CAND -> cand[code-10] +1; otherwise null +1. Then -> SHOW. Keys ignored.
- SHOW: display A,A for SHOW_CYC cycles, then clear d1/d0/blank, IDLE. Keys ignored.
- CLOSED: terminal until reset. Keys ignored, counters frozen, display F,F.
- Counters saturate at 2^CNT_W-1. An increment at the maximum value is dropped; vote_done still pulses.
- close_poll is sampled only in IDLE. Asserted during a vote, it takes effect on the first IDLE cycle after that vote finishes.
- Timeout: in DIGIT2/CONFIRM a counter restarts on every accepted or ignored key_valid. After TIMEOUT cycles with no key -> clear, IDLE, no counter change.

## Timing
- Reset: state IDLE, all counters 0, d1/d0 cleared, rd_data 0, vote_done 0, closed 0, display F,F.
- A key is evaluated at the posedge where key_valid=1; the new state and display are visible the next cycle.
- CONFIRMA accepted at edge N: COMMIT during cycle N+1, counter updated at edge N+1, vote_done high during cycle N+2 (first SHOW cycle).
- SHOW lasts exactly SHOW_CYC cycles, then IDLE.
- rd_data = counter[rd_idx] one cycle after rd_idx is presented. rd_idx > NUM_CAND+1 -> 0. If the read hits a counter being incremented on the same edge, it returns the pre-increment value.
- Reset asserted mid-vote or in CLOSED wins unconditionally on that edge and clears all tallies.

## Test plan
- NUM_CAND=4: keys 1,2,CONFIRMA -> cand[2]=1, vote_done exactly 1 pulse, display A,A for SHOW_CYC cycles, then IDLE.
- Keys 9,9,CONFIRMA -> null=1, candidates unchanged. BRANCO,CONFIRMA -> blank=1, display F,F in CONFIRM.
- Keys 1,CORRIGE,1,3,CORRIGE,1,1,CONFIRMA -> only cand[1]=1. Digits pressed in CONFIRM and keys pressed in SHOW are ignored.
- TIMEOUT=20: key 1, then no key for 20 cycles -> IDLE, all counters 0. Key at cycle 19 restarts the count.
- CNT_W=2: four votes for code 10 -> cand[0]=3, four vote_done pulses. close_poll raised mid-vote -> CLOSED entered right after SHOW; subsequent keys change nothing, rd_idx sweep 0..6 returns final tallies and 0 for 6.
- Reset asserted in CONFIRM and in CLOSED -> IDLE next cycle, all rd_data 0.

Source files
------------

// File: rtl/vote_sequencer_if.sv
// Keypad, tally-readout and display bundle of the ballot-box session controller.
// master = keypad/readout side, slave = vote_sequencer.
interface vote_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic             close_poll;
    logic [6:0]       rd_idx;
    logic [CNT_W-1:0] rd_data;
    logic [3:0]       disp_d1;
    logic [3:0]       disp_d0;
    logic [2:0]       state_o;
    logic             vote_done;
    logic             closed;

    modport master (
        output key_valid, key_code, close_poll, rd_idx,
        input  rd_data, disp_d1, disp_d0, state_o, vote_done, closed
    );

    modport slave (
        input  key_valid, key_code, close_poll, rd_idx,
        output rd_data, disp_d1, disp_d0, state_o, vote_done, closed
    );
endinterface

// File: rtl/vote_sequencer.sv
// Ballot-box session FSM: digit entry, confirm, 1-cycle commit, acknowledge hold; owns saturating tallies.
// Key to new state/display: 1 cycle; rd_data: 1 cycle; no backpressure, ignored keys are dropped.
module vote_sequencer #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int SHOW_CYC = 50000000,
    parameter int TIMEOUT  = 500000000
) (
    input  logic             clock,
    input  logic             reset,
    vote_sequencer_if.slave  bus
);
    localparam int NCNT   = NUM_CAND + 2;
    localparam int SHOW_W = $clog2(SHOW_CYC + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [3:0] K_CONFIRMA = 4'd10;
    localparam logic [3:0] K_CORRIGE  = 4'd11;
    localparam logic [3:0] K_BRANCO   = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DIGIT2  = 3'd1,
        S_CONFIRM = 3'd2,
        S_COMMIT  = 3'd3,
        S_SHOW    = 3'd4,
        S_CLOSED  = 3'd5
    } state_t;

    state_t           r_state;
    logic [3:0]       r_d1;
    logic [3:0]       r_d0;
    logic             r_blank;
    logic [SHOW_W-1:0] r_show_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] r_cnt [NCNT];
    logic [CNT_W-1:0] r_rd_data;
    logic             r_vote_done;

    state_t           w_state_nxt;
    logic             w_is_digit;
    logic             w_timeout;
    logic             w_clear;
    logic             w_latch_d1;
    logic             w_latch_d0;
    logic             w_set_blank;
    logic [6:0]       w_code;
    logic             w_code_ok;
    logic [NCNT-1:0]  w_inc;
    logic [CNT_W-1:0] w_rd_mux;
    logic [3:0]       w_disp_d1;
    logic [3:0]       w_disp_d0;

    assign w_is_digit = (bus.key_code <= 4'd9);
    // Any key, accepted or not, counts as activity and holds off the timeout.
    assign w_timeout  = !bus.key_valid && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign w_code     = 7'(r_d1) * 7'd10 + 7'(r_d0);
    assign w_code_ok  = (w_code >= 7'd10) && (w_code <= 7'(9 + NUM_CAND));

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_latch_d1  = 1'b0;
        w_latch_d0  = 1'b0;
        w_set_blank = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.key_valid && w_is_digit) begin
                    w_latch_d1  = 1'b1;
                    w_state_nxt = S_DIGIT2;
                end else if (bus.key_valid && bus.key_code == K_BRANCO) begin
                    w_set_blank = 1'b1;
                    w_state_nxt = S_CONFIRM;
                end else if (!bus.key_valid && bus.close_poll) begin
                    w_state_nxt = S_CLOSED;
                end
            end
            S_DIGIT2: begin
                if (bus.key_valid && w_is_digit) begin
                    w_latch_d0  = 1'b1;
                    w_state_nxt = S_CONFIRM;
                end else if ((bus.key_valid && bus.key_code == K_CORRIGE) || w_timeout) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONFIRM: begin
                if (bus.key_valid && bus.key_code == K_CONFIRMA) begin
                    w_state_nxt = S_COMMIT;
                end else if ((bus.key_valid && bus.key_code == K_CORRIGE) || w_timeout) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_COMMIT: w_state_nxt = S_SHOW;
            S_SHOW: begin
                if (r_show_cnt == SHOW_W'(SHOW_CYC - 1)) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLOSED: w_state_nxt = S_CLOSED;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_d1    <= 4'd0;
            r_d0    <= 4'd0;
            r_blank <= 1'b0;
        end else if (w_clear) begin
            r_d1    <= 4'd0;
            r_d0    <= 4'd0;
            r_blank <= 1'b0;
        end else begin
            if (w_latch_d1)  r_d1    <= bus.key_code;
            if (w_latch_d0)  r_d0    <= bus.key_code;
            if (w_set_blank) r_blank <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_show_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            r_show_cnt <= (r_state == S_SHOW) ? r_show_cnt + 1'b1 : '0;
            if ((r_state == S_DIGIT2 || r_state == S_CONFIRM) && !bus.key_valid)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else
                r_tmo_cnt <= '0;
        end
    end

    // Top slot is blank, the one below it null; everything else maps code-10.
    always_comb begin
        w_inc = '0;
        if (r_state == S_COMMIT) begin
            if (r_blank) begin
                w_inc[NCNT-1] = 1'b1;
            end else if (w_code_ok) begin
                for (int i = 0; i < NUM_CAND; i++)
                    if (w_code == 7'(10 + i)) w_inc[i] = 1'b1;
            end else begin
                w_inc[NUM_CAND] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NCNT; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCNT; i++)
                if (w_inc[i] && r_cnt[i] != {CNT_W{1'b1}}) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NCNT; i++)
            if (bus.rd_idx == 7'(i)) w_rd_mux = r_cnt[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_data   <= '0;
            r_vote_done <= 1'b0;
        end else begin
            r_rd_data   <= w_rd_mux;
            r_vote_done <= (r_state == S_COMMIT);
        end
    end

    always_comb begin
        w_disp_d1 = 4'hF;
        w_disp_d0 = 4'hF;
        case (r_state)
            S_DIGIT2: w_disp_d1 = r_d1;
            S_CONFIRM, S_COMMIT: begin
                if (!r_blank) begin
                    w_disp_d1 = r_d1;
                    w_disp_d0 = r_d0;
                end
            end
            S_SHOW: begin
                w_disp_d1 = 4'hA;
                w_disp_d0 = 4'hA;
            end
            default: ;
        endcase
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.disp_d1   = w_disp_d1;
    assign bus.disp_d0   = w_disp_d0;
    assign bus.state_o   = r_state;
    assign bus.vote_done = r_vote_done;
    assign bus.closed    = (r_state == S_CLOSED);
endmodule

// File: tb/tb_vote_sequencer.sv
// Scoreboarded bench for vote_sequencer with short SHOW/TIMEOUT and 2-bit counters.
module tb_vote_sequencer;
    localparam int NUM_CAND = 4;
    localparam int CNT_W    = 2;
    localparam int SHOW_CYC = 10;
    localparam int TIMEOUT  = 20;
    localparam int CMAX     = (1 << CNT_W) - 1;
    localparam int NCNT     = NUM_CAND + 2;

    logic clock = 1'b0;
    logic reset;

    vote_sequencer_if #(.CNT_W(CNT_W)) bus ();

    vote_sequencer #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W),
        .SHOW_CYC (SHOW_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_pulse = 0;
    int exp_cnt [NCNT];
    int rd_q [$];

    always @(negedge clock) if (bus.vote_done === 1'b1) n_pulse++;

    task automatic check_val(input string tag, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // All tasks start and end on a negedge; a key set here is seen on the next posedge.
    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int k);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'(k);
        @(negedge clock);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
    endtask

    task automatic model_vote(input bit blank, input int d1, input int d0);
        int code, idx;
        code = 10 * d1 + d0;
        if (blank)                                   idx = NUM_CAND + 1;
        else if (code >= 10 && code <= 9 + NUM_CAND) idx = code - 10;
        else                                         idx = NUM_CAND;
        if (exp_cnt[idx] < CMAX) exp_cnt[idx]++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCNT; i++) exp_cnt[i] = 0;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i <= NCNT; i++) begin
            bus.rd_idx = 7'(i);
            rd_q.push_back(i < NCNT ? exp_cnt[i] : 0);
            @(negedge clock);
            check_val($sformatf("%s rd[%0d]", tag, i), 32'(bus.rd_data), rd_q.pop_front());
        end
        bus.rd_idx = 7'd127;
        rd_q.push_back(0);
        @(negedge clock);
        check_val({tag, " rd[127]"}, 32'(bus.rd_data), rd_q.pop_front());
        bus.rd_idx = 7'd0;
    endtask

    task automatic wait_show(output int n, output int naa);
        n   = 0;
        naa = 0;
        while (bus.state_o == 3'd4 && n < 1000) begin
            n++;
            if ({bus.disp_d1, bus.disp_d0} == 8'hAA) naa++;
            @(negedge clock);
        end
    endtask

    task automatic do_vote(input string tag, input int d1, input int d0);
        int p0, n, naa;
        p0 = n_pulse;
        press(d1);
        press(d0);
        check_val({tag, " confirm state"}, 32'(bus.state_o), 2);
        check_val({tag, " confirm disp"}, {bus.disp_d1, bus.disp_d0}, (d1 << 4) | d0);
        press(10);
        check_val({tag, " commit state"}, 32'(bus.state_o), 3);
        idle(1);
        check_val({tag, " vote_done"}, 32'(bus.vote_done), 1);
        wait_show(n, naa);
        check_val({tag, " show cycles"}, n, SHOW_CYC);
        check_val({tag, " AA cycles"}, naa, SHOW_CYC);
        check_val({tag, " back idle"}, 32'(bus.state_o), 0);
        check_val({tag, " pulses"}, n_pulse - p0, 1);
        model_vote(1'b0, d1, d0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int p0, n, naa;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'd0;
        bus.close_poll = 1'b0;
        bus.rd_idx     = 7'd0;
        reset          = 1'b1;
        model_clear();
        idle(3);
        reset = 1'b0;

        check_val("rst state", 32'(bus.state_o), 0);
        check_val("rst disp", {bus.disp_d1, bus.disp_d0}, 8'hFF);
        check_val("rst vote_done", 32'(bus.vote_done), 0);
        check_val("rst closed", 32'(bus.closed), 0);
        check_val("rst rd_data", 32'(bus.rd_data), 0);

        // Timeout: 19 quiet cycles keep the vote, the 20th discards it.
        press(1);
        check_val("tmo digit2", 32'(bus.state_o), 1);
        check_val("tmo disp", {bus.disp_d1, bus.disp_d0}, 8'h1F);
        idle(19);
        check_val("tmo 19", 32'(bus.state_o), 1);
        idle(1);
        check_val("tmo 20", 32'(bus.state_o), 0);
        press(1);
        idle(18);
        press(2);
        check_val("tmo restart", 32'(bus.state_o), 2);
        idle(19);
        press(7);
        check_val("tmo ignored key", 32'(bus.state_o), 2);
        idle(19);
        check_val("tmo hold", 32'(bus.state_o), 2);
        idle(1);
        check_val("tmo expire", 32'(bus.state_o), 0);
        read_all("tmo");

        do_vote("v12", 1, 2);
        do_vote("v99", 9, 9);

        press(12);
        check_val("blank state", 32'(bus.state_o), 2);
        check_val("blank disp", {bus.disp_d1, bus.disp_d0}, 8'hFF);
        press(10);
        idle(1);
        wait_show(n, naa);
        check_val("blank show", n, SHOW_CYC);
        model_vote(1'b1, 0, 0);

        press(1);
        press(11);
        check_val("corr1", 32'(bus.state_o), 0);
        press(1);
        press(3);
        press(11);
        check_val("corr2", 32'(bus.state_o), 0);
        press(1);
        press(1);
        press(4);
        check_val("digit in confirm", 32'(bus.state_o), 2);
        check_val("digit in confirm disp", {bus.disp_d1, bus.disp_d0}, 8'h11);
        press(10);
        idle(1);
        press(5);
        check_val("key in show", 32'(bus.state_o), 4);
        wait_show(n, naa);
        check_val("after show idle", 32'(bus.state_o), 0);
        model_vote(1'b0, 1, 1);
        read_all("mix");

        p0 = n_pulse;
        for (int v = 0; v < 4; v++) do_vote("sat", 1, 0);
        check_val("sat pulses", n_pulse - p0, 4);
        read_all("sat");

        press(1);
        press(2);
        check_val("pre rst confirm", 32'(bus.state_o), 2);
        do_reset();
        check_val("rst in confirm", 32'(bus.state_o), 0);
        read_all("rst1");

        // Close raised mid-vote: vote completes, one IDLE cycle, then CLOSED.
        press(1);
        bus.close_poll = 1'b1;
        press(3);
        press(10);
        idle(1);
        wait_show(n, naa);
        check_val("close show", n, SHOW_CYC);
        check_val("close first idle", 32'(bus.state_o), 0);
        model_vote(1'b0, 1, 3);
        idle(1);
        check_val("closed state", 32'(bus.state_o), 5);
        check_val("closed flag", 32'(bus.closed), 1);
        check_val("closed disp", {bus.disp_d1, bus.disp_d0}, 8'hFF);
        press(1);
        press(12);
        press(10);
        check_val("closed keys", 32'(bus.state_o), 5);
        read_all("final");
        bus.close_poll = 1'b0;
        do_reset();
        check_val("rst in closed", 32'(bus.state_o), 0);
        check_val("rst closed flag", 32'(bus.closed), 0);
        read_all("rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
